// File: rtl/codificador_pkg.sv
// Shared constants for the BCD-to-Morse encoder.
// Holds the symbol encoding, the digit code table and the keyer states.
package codificador_pkg;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam int NUM_DIGITS = 10;

    // Bit 4 is the first symbol sent (s1), bit 0 the last (s5)
    localparam logic [4:0] MORSE_TABLE [NUM_DIGITS] = '{
        5'b11111,
        5'b01111,
        5'b00111,
        5'b00011,
        5'b00001,
        5'b00000,
        5'b10000,
        5'b11000,
        5'b11100,
        5'b11110
    };

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        GAP
    } keyer_state_t;

    function automatic logic digit_legal(input logic [3:0] digit);
        return digit < 4'd10;
    endfunction

    function automatic logic [4:0] morse_code(input logic [3:0] digit);
        return digit_legal(digit) ? MORSE_TABLE[digit] : 5'b00000;
    endfunction

endpackage

// File: rtl/morse_serializer.sv
// Serial keyer: plays a captured 5-symbol code on key_out.
// Mark is 1 unit (dot) or 3 units (dash), each followed by a 1-unit gap.
module morse_serializer
    import codificador_pkg::*;
#(
    parameter int UNIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] code,
    output logic       key_out,
    output logic       busy
);

    localparam int CW = $clog2(3 * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] DOT_LEN  = CW'(UNIT_CYCLES);
    localparam logic [CW-1:0] DASH_LEN = CW'(3 * UNIT_CYCLES);

    keyer_state_t state;
    keyer_state_t next_state;

    logic [4:0]    code_q;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] phase_len;
    logic          phase_end;

    // Current phase length and end-of-phase detect
    always_comb begin
        phase_len = DOT_LEN;
        if (state == MARK && code_q[4] == DASH) begin
            phase_len = DASH_LEN;
        end
        phase_end = (cnt == phase_len - CW'(1));
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start) next_state = MARK;
            MARK: if (phase_end) next_state = GAP;
            GAP: begin
                if (phase_end) begin
                    next_state = (idx == 3'd4) ? IDLE : MARK;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Code shifter, symbol index and cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_q <= '0;
            idx    <= '0;
            cnt    <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                code_q <= code;
                idx    <= '0;
                cnt    <= '0;
            end
        end else if (phase_end) begin
            cnt <= '0;
            if (state == GAP) begin
                code_q <= {code_q[3:0], 1'b0};
                idx    <= idx + 3'd1;
            end
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Outputs decoded from the state register
    always_comb begin
        key_out = 1'b0;
        busy    = 1'b0;
        unique case (state)
            IDLE: begin
                key_out = 1'b0;
                busy    = 1'b0;
            end
            MARK: begin
                key_out = 1'b1;
                busy    = 1'b1;
            end
            GAP: begin
                key_out = 1'b0;
                busy    = 1'b1;
            end
            default: begin
                key_out = 1'b0;
                busy    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/codificador_em_morse.sv
// BCD digit to 5-symbol Morse encoder with registered parallel output.
// Define CODIFICADOR_SERIAL_EN to add the serial keyer (key_out/busy).
module codificador_em_morse
    import codificador_pkg::*;
#(
    parameter int UNIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic ready,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic s4,
    output logic s5,
    output logic valid,
    output logic err
`ifdef CODIFICADOR_SERIAL_EN
    ,
    output logic key_out,
    output logic busy
`endif
);

    if (UNIT_CYCLES < 1) begin : g_bad_unit
        $error("UNIT_CYCLES must be at least 1");
    end

    logic [3:0] digit;
    logic [4:0] code;
    logic       legal;
    logic       blocked;
    logic       capture;
    logic [4:0] s_q;

    assign digit = {a, b, c, d};
    assign code  = morse_code(digit);
    assign legal = digit_legal(digit);

`ifdef CODIFICADOR_SERIAL_EN
    morse_serializer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_serializer (
        .clk    (clk),
        .reset  (reset),
        .start  (capture & legal),
        .code   (code),
        .key_out(key_out),
        .busy   (busy)
    );
    assign blocked = busy;
`else
    assign blocked = 1'b0;
`endif

    assign capture = ready & ~blocked;

    // Capture register: decoded code and legality flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q   <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else if (capture) begin
            s_q   <= code;
            valid <= legal;
            err   <= ~legal;
        end
    end

    assign s1 = s_q[4];
    assign s2 = s_q[3];
    assign s3 = s_q[2];
    assign s4 = s_q[1];
    assign s5 = s_q[0];

endmodule

// File: tb/tb_codificador_em_morse.sv
// Testbench for codificador_em_morse: table-driven decode checks,
// plus keyer timing sequences when CODIFICADOR_SERIAL_EN is defined.
module tb_codificador_em_morse;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic ready = 1'b0;
    logic s1, s2, s3, s4, s5;
    logic valid, err;
`ifdef CODIFICADOR_SERIAL_EN
    logic key_out, busy;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    codificador_em_morse #(
        .UNIT_CYCLES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .a    (a),
        .b    (b),
        .c    (c),
        .d    (d),
        .ready(ready),
        .s1   (s1),
        .s2   (s2),
        .s3   (s3),
        .s4   (s4),
        .s5   (s5),
        .valid(valid),
        .err  (err)
`ifdef CODIFICADOR_SERIAL_EN
        ,
        .key_out(key_out),
        .busy   (busy)
`endif
    );

    typedef struct {
        logic [3:0] dig;
        logic       rdy;
        logic [4:0] s;
        logic       v;
        logic       e;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] dig, input logic rdy);
        {a, b, c, d} = dig;
        ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef CODIFICADOR_SERIAL_EN
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) begin
            miscompares++;
            vectors++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, n);
        end
    endtask
`endif

    function automatic logic [31:0] outs();
        return {25'd0, s1, s2, s3, s4, s5, valid, err};
    endfunction

    initial begin
        // idle holds after reset
        tbl.push_back('{4'd7, 1'b0, 5'b00000, 1'b0, 1'b0});
        tbl.push_back('{4'd0, 1'b0, 5'b00000, 1'b0, 1'b0});
        // sweep 0..9
        tbl.push_back('{4'd0, 1'b1, 5'b11111, 1'b1, 1'b0});
        tbl.push_back('{4'd1, 1'b1, 5'b01111, 1'b1, 1'b0});
        tbl.push_back('{4'd2, 1'b1, 5'b00111, 1'b1, 1'b0});
        tbl.push_back('{4'd3, 1'b1, 5'b00011, 1'b1, 1'b0});
        tbl.push_back('{4'd4, 1'b1, 5'b00001, 1'b1, 1'b0});
        tbl.push_back('{4'd5, 1'b1, 5'b00000, 1'b1, 1'b0});
        tbl.push_back('{4'd6, 1'b1, 5'b10000, 1'b1, 1'b0});
        tbl.push_back('{4'd7, 1'b1, 5'b11000, 1'b1, 1'b0});
        tbl.push_back('{4'd8, 1'b1, 5'b11100, 1'b1, 1'b0});
        tbl.push_back('{4'd9, 1'b1, 5'b11110, 1'b1, 1'b0});
        // illegal then legal 5
        tbl.push_back('{4'd12, 1'b1, 5'b00000, 1'b0, 1'b1});
        tbl.push_back('{4'd5, 1'b1, 5'b00000, 1'b1, 1'b0});
        // capture 6 then hold while inputs change
        tbl.push_back('{4'd6, 1'b1, 5'b10000, 1'b1, 1'b0});
        tbl.push_back('{4'd3, 1'b0, 5'b10000, 1'b1, 1'b0});
        tbl.push_back('{4'd15, 1'b0, 5'b10000, 1'b1, 1'b0});
        tbl.push_back('{4'd9, 1'b0, 5'b10000, 1'b1, 1'b0});
        // other illegal codes
        tbl.push_back('{4'd10, 1'b1, 5'b00000, 1'b0, 1'b1});
        tbl.push_back('{4'd15, 1'b1, 5'b00000, 1'b0, 1'b1});
        tbl.push_back('{4'd4, 1'b1, 5'b00001, 1'b1, 1'b0});

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs(), 32'd0);
        reset = 1'b1;
        tick();
        check("after_release", outs(), 32'd0);

        foreach (tbl[i]) begin
`ifdef CODIFICADOR_SERIAL_EN
            wait_idle();
`endif
            drive(tbl[i].dig, tbl[i].rdy);
            tick();
            check($sformatf("vec%0d_dig%0d", i, tbl[i].dig), outs(),
                  {25'd0, tbl[i].s, tbl[i].v, tbl[i].e});
        end
        drive(4'd0, 1'b0);

`ifdef CODIFICADOR_SERIAL_EN
        begin
            // digit 1 = dot dash dash dash dash, unit = 2 cycles
            int marks[5] = '{2, 6, 6, 6, 6};
            logic exp_key[$];
            wait_idle();
            tick();
            for (int s = 0; s < 5; s++) begin
                for (int k = 0; k < marks[s]; k++) exp_key.push_back(1'b1);
                for (int k = 0; k < 2; k++) exp_key.push_back(1'b0);
            end
            check("pattern_len", exp_key.size(), 36);
            drive(4'd1, 1'b1);
            tick();
            drive(4'd8, 1'b0);
            for (int k = 0; k < 40; k++) begin
                logic ek;
                logic eb;
                ek = (k < 36) ? exp_key[k] : 1'b0;
                eb = (k < 36);
                check($sformatf("key_c%0d", k), {30'd0, key_out, busy},
                      {30'd0, ek, eb});
                ready = ((k >= 5 && k <= 10) || k == 20);
                tick();
            end
            ready = 1'b0;
            check("hold_during_busy", outs(), {25'd0, 5'b01111, 2'b10});

            // illegal capture never starts the keyer
            drive(4'd12, 1'b1);
            tick();
            drive(4'd0, 1'b0);
            check("err_no_key", {29'd0, err, busy, key_out}, 32'b100);
            tick();
            check("err_no_key2", {30'd0, busy, key_out}, 32'd0);

            // reset mid-keying, checked between clock edges
            drive(4'd0, 1'b1);
            tick();
            drive(4'd0, 1'b0);
            repeat (4) tick();
            check("mid_key_busy", {31'd0, busy}, 32'd1);
            #2;
            reset = 1'b0;
            #1;
            check("async_reset", {23'd0, key_out, busy, outs()[6:0]},
                  32'd0);
            tick();
            reset = 1'b1;
            tick();
            check("post_reset_idle", {23'd0, key_out, busy, outs()[6:0]},
                  32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
